// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS per AHB transfer,
// with PREADY wait states, PSLVERR mapped to the two-cycle AHB ERROR response.
module ahb2apb_bridge #(
  parameter int PADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [PADDR_W-1:0] PADDR,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  output logic [3:0]         PSTRB,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_e;

  state_e               state_q, state_d;
  logic [PADDR_W-1:0]   paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [3:0]           pstrb_q, pstrb_d;
  logic [31:0]          hrdata_q, hrdata_d;

  logic                 accept;
  logic                 illegal;
  logic [3:0]           strb;

  // Upper address bits and HTRANS[0] carry no information for the APB side.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:PADDR_W], HTRANS[0]};

  // Handshake: a transfer is taken only when this bridge can start a new one
  // (IDLE/DONE/ERR2) and the address phase is qualified by the system HREADY.
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2))
                  && HSEL && HTRANS[1] && HREADY;

  always_comb begin
    illegal = 1'b0;
    strb    = 4'b1111;
    case (HSIZE)
      3'd0: strb = 4'b0001 << HADDR[1:0];
      3'd1: begin
        strb    = 4'b0011 << HADDR[1:0];
        illegal = HADDR[0];
      end
      3'd2: illegal = (HADDR[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    hrdata_d = hrdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          state_d  = illegal ? S_ERR1 : S_WAIT;
          paddr_d  = HADDR[PADDR_W-1:0];
          pwrite_d = HWRITE;
          pstrb_d  = HWRITE ? strb : 4'b0000;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (pwrite_q) pwdata_d = HWDATA;
        state_d = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_d = S_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = PRDATA;
            state_d = S_DONE;
          end
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Control outputs decode straight from the state flop so an async reset
  // drops PSEL/PENABLE and releases HREADYOUT in the same cycle.
  assign PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE   = (state_q == S_ACCESS);
  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_SETUP) ||
                       (state_q == S_ACCESS) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: single-slave response mux, APB side
// driven by hand, expected values computed by hand for each step.
module tb_ahb2apb_bridge;

  logic        clk;
  logic        rst_n;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_assert = 0;
  int n_fail   = 0;

  // Only slave on the bus: the response mux passes HREADYOUT straight back.
  assign HREADY = HREADYOUT;

  ahb2apb_bridge #(.PADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    HSEL   = 1'b1;
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = w;
    HSIZE  = sz;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 32'h0;
    HSIZE  = 3'd0;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus_idle();
    HWDATA  = 32'h0;
    PRDATA  = 32'h0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    tick();
    tick();
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'd1);
    check("rst_hresp",     {31'h0, HRESP},     32'd0);
    check("rst_hrdata",    HRDATA,             32'h0);
    check("rst_psel",      {31'h0, PSEL},      32'd0);
    check("rst_penable",   {31'h0, PENABLE},   32'd0);
    check("rst_pwrite",    {31'h0, PWRITE},    32'd0);
    check("rst_paddr",     {16'h0, PADDR},     32'h0);
    check("rst_pwdata",    PWDATA,             32'h0);
    check("rst_pstrb",     {28'h0, PSTRB},     32'h0);
    rst_n = 1'b1;
    tick();

    // IDLE transfer type while selected: OKAY, no wait states.
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h4000_0000;
    tick();
    check("idle_type_ready", {31'h0, HREADYOUT}, 32'd1);
    check("idle_type_psel",  {31'h0, PSEL},      32'd0);
    bus_idle();

    // Word write, zero-wait APB.
    addr_phase(32'h4000_0010, 1'b1, 3'd2);
    tick();
    check("wr_c1_ready", {31'h0, HREADYOUT}, 32'd0);
    check("wr_c1_psel",  {31'h0, PSEL},      32'd0);
    bus_idle();
    HWDATA = 32'hDEAD_BEEF;
    tick();
    HWDATA = 32'h0;
    check("wr_setup_psel",    {31'h0, PSEL},    32'd1);
    check("wr_setup_penable", {31'h0, PENABLE}, 32'd0);
    check("wr_setup_paddr",   {16'h0, PADDR},   32'h0010);
    check("wr_setup_pstrb",   {28'h0, PSTRB},   32'hF);
    check("wr_setup_pwdata",  PWDATA,           32'hDEAD_BEEF);
    check("wr_setup_pwrite",  {31'h0, PWRITE},  32'd1);
    tick();
    check("wr_access_penable", {31'h0, PENABLE}, 32'd1);
    check("wr_access_pwdata",  PWDATA,           32'hDEAD_BEEF);
    check("wr_access_paddr",   {16'h0, PADDR},   32'h0010);
    check("wr_access_ready",   {31'h0, HREADYOUT}, 32'd0);
    tick();
    check("wr_c4_ready", {31'h0, HREADYOUT}, 32'd1);
    check("wr_c4_hresp", {31'h0, HRESP},     32'd0);
    check("wr_c4_psel",  {31'h0, PSEL},      32'd0);
    tick();

    // Word read, PREADY low for three ACCESS cycles.
    PREADY = 1'b0;
    PRDATA = 32'hAAAA_0000;
    addr_phase(32'h4000_0020, 1'b0, 3'd2);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus_idle();
      check($sformatf("rd_wait_c%0d_penable", c), {31'h0, PENABLE},
            {31'h0, (c >= 3 && c <= 6)});
      check($sformatf("rd_wait_c%0d_ready", c), {31'h0, HREADYOUT},
            {31'h0, (c == 7)});
      if (c == 2) check("rd_wait_pstrb", {28'h0, PSTRB}, 32'h0);
      if (c == 6) begin
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
      end
    end
    check("rd_wait_hrdata", HRDATA, 32'h1234_5678);
    check("rd_wait_hresp",  {31'h0, HRESP}, 32'd0);
    PRDATA = 32'h0;
    tick();

    // Read answered with PSLVERR.
    PSLVERR = 1'b1;
    PRDATA  = 32'hBAD0_BAD0;
    addr_phase(32'h4000_0030, 1'b0, 3'd2);
    tick();
    bus_idle();
    tick();
    tick();
    check("slverr_access", {31'h0, PENABLE}, 32'd1);
    tick();
    PSLVERR = 1'b0;
    check("err1_ready", {31'h0, HREADYOUT}, 32'd0);
    check("err1_hresp", {31'h0, HRESP},     32'd1);
    check("err1_psel",  {31'h0, PSEL},      32'd0);
    tick();
    check("err2_ready",  {31'h0, HREADYOUT}, 32'd1);
    check("err2_hresp",  {31'h0, HRESP},     32'd1);
    check("err_hrdata_held", HRDATA, 32'h1234_5678);
    tick();
    check("post_err_ready", {31'h0, HREADYOUT}, 32'd1);
    check("post_err_hresp", {31'h0, HRESP},     32'd0);

    // Misaligned half-word: ERROR, no APB activity.
    addr_phase(32'h4000_0001, 1'b0, 3'd1);
    tick();
    bus_idle();
    check("mis_err1_ready", {31'h0, HREADYOUT}, 32'd0);
    check("mis_err1_hresp", {31'h0, HRESP},     32'd1);
    check("mis_err1_psel",  {31'h0, PSEL},      32'd0);
    tick();
    check("mis_err2_hresp", {31'h0, HRESP},     32'd1);
    check("mis_err2_ready", {31'h0, HREADYOUT}, 32'd1);
    check("mis_err2_psel",  {31'h0, PSEL},      32'd0);
    tick();
    check("mis_idle_hresp", {31'h0, HRESP},     32'd0);

    // Byte write at offset 2.
    addr_phase(32'h4000_0012, 1'b1, 3'd0);
    tick();
    bus_idle();
    HWDATA = 32'h00AB_0000;
    tick();
    check("byte_psel",  {31'h0, PSEL},  32'd1);
    check("byte_pstrb", {28'h0, PSTRB}, 32'h4);
    check("byte_paddr", {16'h0, PADDR}, 32'h0012);
    check("byte_pwdata", PWDATA,        32'h00AB_0000);
    tick();
    tick();
    check("byte_done_ready", {31'h0, HREADYOUT}, 32'd1);
    tick();

    // Back-to-back reads, second address phase during DONE.
    PRDATA = 32'h1111_1111;
    addr_phase(32'h4000_0040, 1'b0, 3'd2);
    tick();
    bus_idle();
    tick();
    tick();
    check("b2b_c3_psel", {31'h0, PSEL}, 32'd1);
    tick();
    check("b2b_done1_ready",  {31'h0, HREADYOUT}, 32'd1);
    check("b2b_done1_hrdata", HRDATA,             32'h1111_1111);
    check("b2b_done1_psel",   {31'h0, PSEL},      32'd0);
    addr_phase(32'h4000_0044, 1'b0, 3'd2);
    PRDATA = 32'h2222_2222;
    tick();
    bus_idle();
    check("b2b_wait2_ready", {31'h0, HREADYOUT}, 32'd0);
    check("b2b_wait2_psel",  {31'h0, PSEL},      32'd0);
    tick();
    check("b2b_setup2_psel",  {31'h0, PSEL},  32'd1);
    check("b2b_setup2_paddr", {16'h0, PADDR}, 32'h0044);
    tick();
    tick();
    check("b2b_done2_ready",  {31'h0, HREADYOUT}, 32'd1);
    check("b2b_done2_hrdata", HRDATA,             32'h2222_2222);
    tick();

    // Reset asserted while stalled in ACCESS.
    PREADY = 1'b0;
    addr_phase(32'h4000_0050, 1'b1, 3'd2);
    tick();
    bus_idle();
    HWDATA = 32'hCAFE_F00D;
    tick();
    tick();
    check("mid_access_penable", {31'h0, PENABLE}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_psel",    {31'h0, PSEL},      32'd0);
    check("mid_rst_penable", {31'h0, PENABLE},   32'd0);
    check("mid_rst_ready",   {31'h0, HREADYOUT}, 32'd1);
    check("mid_rst_hresp",   {31'h0, HRESP},     32'd0);
    check("mid_rst_hrdata",  HRDATA,             32'h0);
    check("mid_rst_paddr",   {16'h0, PADDR},     32'h0);
    tick();
    rst_n  = 1'b1;
    PREADY = 1'b1;
    tick();

    // After release the bridge starts a fresh transfer from IDLE.
    PRDATA = 32'h5A5A_5A5A;
    addr_phase(32'h4000_0060, 1'b0, 3'd2);
    tick();
    bus_idle();
    check("post_rst_wait_ready", {31'h0, HREADYOUT}, 32'd0);
    tick();
    check("post_rst_setup_psel", {31'h0, PSEL}, 32'd1);
    tick();
    tick();
    check("post_rst_done_ready",  {31'h0, HREADYOUT}, 32'd1);
    check("post_rst_done_hrdata", HRDATA,             32'h5A5A_5A5A);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
- AHB-Lite slave to APB4 master bridge for the peripheral region of the SoC.
- Its HRDATA/HREADYOUT/HRESP outputs feed the AHB slave response mux as that mux's peripheral-slot inputs. The mux drives the system HREADY, which comes back here as HREADY.
- Converts each AHB transfer into one APB SETUP/ACCESS sequence and honours PREADY wait states and PSLVERR.
- Returns read data registered and produces the standard two-cycle AHB ERROR response.

Parameters:
- PADDR_W, 16, APB address width; PADDR = HADDR[PADDR_W-1:0].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- HSEL  in  1  bridge select from address decoder
- HADDR  in  32  AHB address
- HTRANS  in  2  AHB transfer type; bit1 = NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  system HREADY from the response mux
- HRDATA  out  32  read data to the response mux
- HREADYOUT  out  1  ready to the response mux
- HRESP  out  1  1 = ERROR
- PADDR  out  PADDR_W  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB write strobes; 0 for reads
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (async, rst_n=0) values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0.
  - FSM in IDLE.
  - Reset mid-transfer aborts immediately to these values; no APB completion is attempted.
- Transfer accept:
  - Condition: HSEL & HTRANS[1] & HREADY, evaluated in IDLE, DONE or ERR2 only.
  - On accept, register HADDR, HWRITE and HSIZE.
  - IDLE/BUSY transfer types are ignored and get an OKAY zero-wait response.
- Illegal transfer: HSIZE>2, or misaligned (half-word with HADDR[0]=1, word with HADDR[1:0]!=0). It goes straight to ERR1 with no APB activity.
- PSTRB for writes:
  - byte: 1<<HADDR[1:0]
  - half-word: 4'b0011 << HADDR[1:0]
  - word: 4'b1111
- FSM states and outputs:
  - IDLE: HREADYOUT=1, HRESP=0. Legal accept -> WAIT; illegal accept -> ERR1.
  - WAIT (first data-phase cycle): HREADYOUT=0. Latch HWDATA into PWDATA (writes only) -> SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0 -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. PADDR/PWRITE/PWDATA/PSTRB held stable.
    - PREADY=0: stay.
    - PREADY=1 & !PSLVERR: latch PRDATA into HRDATA (reads only) -> DONE.
    - PREADY=1 & PSLVERR: -> ERR1.
  - DONE: PSEL=0, HREADYOUT=1, HRESP=0. Accept -> WAIT/ERR1, else -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept -> WAIT/ERR1, else -> IDLE.
- Latency with zero-wait APB: 4 data-phase cycles, i.e. HREADYOUT=1 on the 4th cycle after the address phase. Each APB PREADY=0 cycle adds 1.
- Back-to-back transfers: a new address phase coincident with DONE/ERR2 is accepted without passing through IDLE.
- HRDATA holds its last value until the next successful read completes. PSEL deasserts for at least one cycle between APB transfers.

Test Plan:
- Reset with rst_n=0 mid-ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0 in the same cycle; FSM in IDLE after release.
- Word write HADDR=0x4000_0010, HWDATA=0xDEADBEEF, PREADY=1 -> PADDR=0x0010, PSTRB=4'hF, PWDATA=0xDEADBEEF through SETUP and ACCESS; HREADYOUT=1 four cycles after the address phase, HRESP=0.
- Word read with PREADY low for 3 ACCESS cycles, PRDATA=0x1234_5678 -> PENABLE held 4 cycles, then HRDATA=0x12345678 with HREADYOUT=1 at data-phase cycle 7.
- Read with PSLVERR=1 at PREADY -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), then OKAY.
- Half-word at HADDR[1:0]=01 -> ERROR response, PSEL never asserted. Byte write at HADDR[1:0]=10 -> PSTRB=4'b0100.
- Two back-to-back word reads, the second addressed during DONE -> second WAIT immediately follows DONE; PSEL low exactly 2 cycles between transfers.
